// File: rtl/dm_pkg.sv
// Shared encodings for the wait-state data memory: access sizes, FSM states
// and the alignment rule used to reject an access before it reaches the array.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    // The reserved size is reported as misaligned so it never touches the array.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a[0];
            SZ_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting: merges right-aligned store data into a word with a
// byte mask, and extracts/extends a load lane. Purely combinational.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  a_i,
    input  logic        uns_i,
    output logic [31:0] new_word_o,
    output logic [3:0]  bmask_o,
    output logic [31:0] ld_val_o
);

    logic [31:0] shifted;
    logic [31:0] lane;

    always_comb begin
        shifted = wdata_i << {a_i, 3'b000};
        lane    = old_word_i >> {a_i, 3'b000};
        case (size_i)
            SZ_B:    bmask_o = 4'b0001 << a_i;
            SZ_H:    bmask_o = a_i[1] ? 4'b1100 : 4'b0011;
            default: bmask_o = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++)
            new_word_o[8*i +: 8] = bmask_o[i] ? shifted[8*i +: 8] : old_word_i[8*i +: 8];
        case (size_i)
            SZ_B:    ld_val_o = uns_i ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    ld_val_o = uns_i ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ld_val_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/dm_wait_ctrl.sv
// Data memory with req/ready handshake and WAIT_CYCLES wait states.
// Define DM_TRACE_EN to print completed stores and misaligned requests.
module dm_wait_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2  = 7,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    if (DATA_W != 32) begin : g_bad_width
        $error("dm_wait_ctrl: only DATA_W = 32 is supported");
    end

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  we_q, uns_q;
    logic [1:0]            size_q;
    logic [DEPTH_LOG2+1:0] addr_q;
    logic [31:0]           wdata_q, res_q, rdata_q;
    logic                  err_q, ready_q, err_out_q;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] widx;
    logic [31:0]           old_word, new_word, ld_val;
    logic [3:0]            bmask;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

    assign widx     = addr_q[DEPTH_LOG2+1:2];
    assign old_word = mem_q[widx];
    assign busy     = (state_q != IDLE);
    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign err      = err_out_q;

    dm_lane_fmt u_fmt (
        .old_word_i (old_word),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .a_i        (addr_q[1:0]),
        .uns_i      (uns_q),
        .new_word_o (new_word),
        .bmask_o    (bmask),
        .ld_val_o   (ld_val)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_out_q <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_out_q <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    we_q    <= we;
                    uns_q   <= uns;
                    size_q  <= size;
                    addr_q  <= addr[DEPTH_LOG2+1:0];
                    wdata_q <= wdata;
                    res_q   <= '0;
                    cnt_q   <= '0;
                    if (is_misaligned(size, addr[1:0])) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) state_q <= ACCESS;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                ACCESS: begin
                    res_q   <= we_q ? '0 : ld_val;
                    state_q <= RESP;
                end
                RESP: begin
                    ready_q   <= 1'b1;
                    rdata_q   <= res_q;
                    err_out_q <= err_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is deliberately left out of reset; only the masked lanes are written.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q) begin
            for (int i = 0; i < 4; i++)
                if (bmask[i]) mem_q[widx][8*i +: 8] <= new_word[8*i +: 8];
        end
    end

`ifdef DM_TRACE_EN
    always @(posedge clk) begin
        if (rstn && state_q == ACCESS && we_q)
            $display("%0t dmem[0x%08h] = 0x%08h (mask %b)", $time,
                     32'({widx, 2'b00}), new_word, bmask);
        if (rstn && state_q == IDLE && req && is_misaligned(size, addr[1:0]))
            $display("%0t warning: misaligned access addr=0x%08h size=%0d", $time, addr, size);
    end
`else
    // Trace disabled: no display statements are compiled.
`endif

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Directed bench for dm_wait_ctrl: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=0 instance for the zero-wait latency case.
module tb_dm_wait_ctrl;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        req = 1'b0, req0 = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, err, busy, ready0, err0, busy0;
    logic [31:0] rdata, rdata0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dm_wait_ctrl #(.DEPTH_LOG2(7), .WAIT_CYCLES(2), .DATA_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .busy(busy));

    dm_wait_ctrl #(.DEPTH_LOG2(7), .WAIT_CYCLES(0), .DATA_W(32)) u_dut0 (
        .clk(clk), .rstn(rstn), .req(req0), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0));

    // Drives one request; returns result, ready latency in edges after accept, busy cycles.
    task automatic do_access(input bit s0, input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic e, output int lat, output int bc);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        if (s0) req0 = 1'b1; else req = 1'b1;
        rd = 32'hDEAD_DEAD; e = 1'bx; lat = -1; bc = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin req = 1'b0; req0 = 1'b0; end
            if (s0 ? busy0 : busy) bc++;
            if (s0 ? ready0 : ready) begin
                lat = k; rd = s0 ? rdata0 : rdata; e = s0 ? err0 : err;
                break;
            end
        end
    endtask

    logic [31:0] rd; logic e; int lat, bc;

    task automatic test_reset();
        #12;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_word();
        do_access(0, 1, 2'b10, 0, 32'h10, 32'h12345678, rd, e, lat, bc);
        checks++; if (lat !== 4 || rd !== 32'h0 || e !== 1'b0) begin errors++;
            $display("FAIL word_store: lat %0d rdata %h err %b, exp lat 4 rdata 0 err 0", lat, rd, e); end
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, e, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL word_load_lat: got %0d exp 4", lat); end
        checks++; if (rd !== 32'h12345678 || e !== 1'b0) begin errors++;
            $display("FAIL word_load: got %h err %b exp 12345678 err 0", rd, e); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL word_busy_cycles: got %0d exp 4", bc); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: got %b exp 0", ready); end
    endtask

    task automatic test_byte();
        do_access(0, 1, 2'b10, 0, 32'h10, 32'h0, rd, e, lat, bc);
        do_access(0, 1, 2'b00, 0, 32'h13, 32'h123456AB, rd, e, lat, bc);
        checks++; if (lat !== 4 || e !== 1'b0) begin errors++; $display("FAIL byte_store: lat %0d err %b exp 4/0", lat, e); end
        do_access(0, 0, 2'b00, 0, 32'h13, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_load_s: got %h exp ffffffab", rd); end
        do_access(0, 0, 2'b00, 1, 32'h13, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL byte_load_u: got %h exp 000000ab", rd); end
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'hAB000000) begin errors++; $display("FAIL byte_word_view: got %h exp ab000000", rd); end
    endtask

    task automatic test_half();
        do_access(0, 1, 2'b10, 0, 32'h20, 32'h55667788, rd, e, lat, bc);
        do_access(0, 1, 2'b01, 0, 32'h22, 32'hCDEF8001, rd, e, lat, bc);
        do_access(0, 0, 2'b01, 0, 32'h22, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL half_load_s: got %h exp ffff8001", rd); end
        do_access(0, 0, 2'b01, 1, 32'h22, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL half_load_u: got %h exp 00008001", rd); end
        do_access(0, 0, 2'b00, 1, 32'h20, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL half_byte20: got %h exp 00000088", rd); end
        do_access(0, 0, 2'b00, 1, 32'h21, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL half_byte21: got %h exp 00000077", rd); end
        do_access(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h80017788) begin errors++; $display("FAIL half_word_view: got %h exp 80017788", rd); end
    endtask

    task automatic test_misaligned();
        do_access(0, 1, 2'b10, 0, 32'h04, 32'h11223344, rd, e, lat, bc);
        do_access(0, 0, 2'b10, 0, 32'h06, 32'h0, rd, e, lat, bc);
        checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++;
            $display("FAIL mis_word_load: lat %0d err %b rdata %h exp 1/1/0", lat, e, rd); end
        do_access(0, 1, 2'b01, 0, 32'h07, 32'hFFFFFFFF, rd, e, lat, bc);
        checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++;
            $display("FAIL mis_half_store: lat %0d err %b rdata %h exp 1/1/0", lat, e, rd); end
        do_access(0, 1, 2'b11, 0, 32'h04, 32'hFFFFFFFF, rd, e, lat, bc);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL mis_rsv_size: lat %0d err %b exp 1/1", lat, e); end
        do_access(0, 0, 2'b10, 0, 32'h04, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h11223344 || e !== 1'b0) begin errors++;
            $display("FAIL mis_array_intact: got %h err %b exp 11223344 err 0", rd, e); end
    endtask

    task automatic test_reset_abort();
        do_access(0, 1, 2'b10, 0, 32'h30, 32'h0A0B0C0D, rd, e, lat, bc);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_wait: busy %b exp 1", busy); end
        rstn = 1'b0; #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin errors++;
            $display("FAIL abort_outputs: busy %b ready %b rdata %h err %b exp all 0", busy, ready, rdata, err); end
        @(negedge clk); rstn = 1'b1;
        do_access(0, 0, 2'b10, 0, 32'h30, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h0A0B0C0D) begin errors++; $display("FAIL abort_mem_kept: got %h exp 0a0b0c0d", rd); end
    endtask

    task automatic test_alias();
        do_access(0, 0, 2'b10, 0, 32'h210, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'hAB000000) begin errors++; $display("FAIL alias_load: got %h exp ab000000", rd); end
        do_access(0, 1, 2'b10, 0, 32'hFFFF_FE50, 32'h600DCAFE, rd, e, lat, bc);
        do_access(0, 0, 2'b10, 0, 32'h50, 32'h0, rd, e, lat, bc);
        checks++; if (rd !== 32'h600DCAFE) begin errors++; $display("FAIL alias_store: got %h exp 600dcafe", rd); end
    endtask

    task automatic test_wait0();
        do_access(1, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, rd, e, lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w0_store_lat: got %0d exp 2", lat); end
        do_access(1, 0, 2'b10, 0, 32'h40, 32'h0, rd, e, lat, bc);
        checks++; if (lat !== 2 || rd !== 32'hCAFEF00D) begin errors++;
            $display("FAIL w0_load: lat %0d rdata %h exp 2/cafef00d", lat, rd); end
    endtask

    task automatic test_back_to_back();
        int acc, nrdy, prev_busy;
        int redge[3];
        logic [31:0] rval[3];
        acc = 0; nrdy = 0; prev_busy = 0;
        @(negedge clk);
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (busy && !prev_busy) acc++;
            if (acc >= 3) req = 1'b0;
            prev_busy = int'(busy);
            if (ready) begin
                if (nrdy < 3) begin redge[nrdy] = k; rval[nrdy] = rdata; end
                nrdy++;
            end
        end
        req = 1'b0;
        checks++; if (nrdy !== 3 || acc !== 3) begin errors++;
            $display("FAIL b2b_count: ready %0d accepts %0d exp 3/3", nrdy, acc); end
        if (nrdy >= 3) begin
            checks++; if (redge[0] !== 4 || redge[1] - redge[0] !== 5 || redge[2] - redge[1] !== 5) begin errors++;
                $display("FAIL b2b_spacing: edges %0d %0d %0d exp 4 9 14", redge[0], redge[1], redge[2]); end
            checks++; if (rval[0] !== 32'h80017788 || rval[1] !== 32'h80017788 || rval[2] !== 32'h80017788) begin errors++;
                $display("FAIL b2b_data: %h %h %h exp 80017788", rval[0], rval[1], rval[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_reset_abort();
        test_alias();
        test_wait0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
